fft_result_unloader: RTL and testbench



---
 rtl/fft_result_unloader_if.sv | 36 +++
 rtl/fft_result_unloader.sv | 171 +++++++++++++++++
 tb/tb_fft_result_unloader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_unloader_if.sv
// Result-unload bus: SRAM read port toward the result bank
// plus the valid/ready sample stream toward the consumer.
interface fft_result_unloader_if #(
  parameter int DATA_W = 32
);
  logic              o_sram_rd_en;
  logic              o_sram_rd_bank;
  logic [9:0]        o_sram_rd_addr;
  logic [DATA_W-1:0] i_sram_rd_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;

  modport master (
    output o_sram_rd_en,
    output o_sram_rd_bank,
    output o_sram_rd_addr,
    input  i_sram_rd_data,
    output o_data,
    output o_valid,
    input  i_ready,
    output o_last
  );

  modport slave (
    input  o_sram_rd_en,
    input  o_sram_rd_bank,
    input  o_sram_rd_addr,
    output i_sram_rd_data,
    input  o_data,
    input  o_valid,
    output i_ready,
    input  o_last
  );
endinterface

// File: rtl/fft_result_unloader.sv
// FFT result unloader: reads the final bank in bit-reversed
// order and streams samples with credit-based backpressure.
module fft_result_unloader #(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [2:0]            i_point_configuration,
  input  logic                  i_fft_done,
  input  logic                  i_sram_read_register,
  fft_result_unloader_if.master bus,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int PW =
    (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT_CLR
  } state_t;

  state_t state_q, state_d;

  logic                  flag_q;
  logic [2:0]            cfg_q, cfg_d;
  logic                  bank_q, bank_d;
  logic [10:0]           k_q, k_d;
  logic                  done_q, done_d;
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [RD_LATENCY-1:0] pl_q, pl_d;
  logic [DATA_W-1:0]     buf_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  blast_q;
  logic [PW-1:0]         wp_q, rp_q;
  logic [3:0]            occ_q, occ_d;
  logic [3:0]            infl;
  logic [10:0]           k_max;
  logic [9:0]            rev [8];
  logic                  start;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic                  head_last;
  logic                  last_k;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign start = (state_q == IDLE) &&
                 i_fft_done && !flag_q;
  assign k_max  = (11'd8 << cfg_q) - 11'd1;
  assign last_k = (k_q == k_max);

  assign valid     = (occ_q != 4'd0);
  assign head_last = valid && blast_q[rp_q];
  assign pop       = valid && bus.i_ready;
  assign push      = pv_q[RD_LATENCY-1];

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      infl = infl + {3'b0, pv_q[i]};
  end

  // A slot freed by this cycle's pop counts as credit,
  // which keeps the stream at one beat per cycle.
  assign issue = (state_q == READ) &&
                 ((occ_q + infl - {3'b0, pop}) <
                  4'(BUF_DEPTH));

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      rev[c] = '0;
      for (int i = 0; i < c + 3; i++)
        rev[c][i] = k_q[c + 2 - i];
    end
  end

  assign pv_d  = RD_LATENCY'({pv_q, issue});
  assign pl_d  = RD_LATENCY'({pl_q, issue && last_k});
  assign occ_d = occ_q + {3'b0, push} - {3'b0, pop};

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    bank_d  = bank_q;
    k_d     = k_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cfg_d   = i_point_configuration;
          bank_d  = i_sram_read_register;
          k_d     = '0;
        end
      end
      READ: begin
        if (issue) begin
          k_d = k_q + 11'd1;
          if (last_k) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!i_fft_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      flag_q  <= i_fft_done;
      cfg_q   <= '0;
      bank_q  <= 1'b0;
      k_q     <= '0;
      done_q  <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
      occ_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      blast_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= i_fft_done;
      cfg_q   <= cfg_d;
      bank_q  <= bank_d;
      k_q     <= k_d;
      done_q  <= done_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      occ_q   <= occ_d;
      if (push) begin
        buf_q[wp_q]   <= bus.i_sram_rd_data;
        blast_q[wp_q] <= pl_q[RD_LATENCY-1];
        wp_q          <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
    end
  end

  assign bus.o_sram_rd_en   = issue;
  assign bus.o_sram_rd_bank = bank_q;
  assign bus.o_sram_rd_addr =
    (state_q == READ) ? rev[cfg_q] : '0;
  assign bus.o_valid = valid;
  assign bus.o_data  = valid ? buf_q[rp_q] : '0;
  assign bus.o_last  = head_last;

  assign o_busy = (state_q == READ) ||
                  (state_q == DRAIN);
  assign o_done = done_q;
endmodule

// File: tb/tb_fft_result_unloader.sv
// Directed bench: two unloaders (read latency 1 and 3)
// against an SRAM model with an in-line scoreboard.
module tb_fft_result_unloader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, done, bank, rdy1, rdy3;
  logic [2:0] cfg;
  logic       busy1, done1, busy3, done3;

  fft_result_unloader_if #(.DATA_W(32)) b1 ();
  fft_result_unloader_if #(.DATA_W(32)) b3 ();

  fft_result_unloader #(.RD_LATENCY(1)) u_d1 (
    .clk                   (clk),
    .i_reset               (rst),
    .i_point_configuration (cfg),
    .i_fft_done            (done),
    .i_sram_read_register  (bank),
    .bus                   (b1),
    .o_busy                (busy1),
    .o_done                (done1)
  );

  fft_result_unloader #(.RD_LATENCY(3)) u_d3 (
    .clk                   (clk),
    .i_reset               (rst),
    .i_point_configuration (cfg),
    .i_fft_done            (done),
    .i_sram_read_register  (bank),
    .bus                   (b3),
    .o_busy                (busy3),
    .o_done                (done3)
  );

  function automatic logic [31:0] mw(
    input logic b, input logic [9:0] a
  );
    return {7'h55, b, 6'h0, a, 8'hC3};
  endfunction

  function automatic logic [9:0] rev(
    input int k, input int l
  );
    int x;
    logic [9:0] r;
    x = k;
    r = '0;
    for (int i = 0; i < l; i++) begin
      r = {r[8:0], x[0]};
      x = x >> 1;
    end
    return r;
  endfunction

  logic [31:0] p1, p3a, p3b, p3c;
  always @(posedge clk) begin
    p1  <= mw(b1.o_sram_rd_bank, b1.o_sram_rd_addr);
    p3a <= mw(b3.o_sram_rd_bank, b3.o_sram_rd_addr);
    p3b <= p3a;
    p3c <= p3b;
  end
  assign b1.i_sram_rd_data = p1;
  assign b3.i_sram_rd_data = p3c;
  assign b1.i_ready = rdy1;
  assign b3.i_ready = rdy3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int ecfg, st;
  logic ebank;
  bit rnd;

  int rd_n[2], bt_n[2], done_n[2], done_c[2];
  int first_v[2], first_b[2], last_b[2], occ_max[2];
  logic [9:0] fa[2][4];
  logic [9:0] la[2];
  logic hv[2];
  logic [31:0] hd[2];

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int u = 0; u < 2; u++) begin
      rd_n[u] = 0; bt_n[u] = 0;
      done_n[u] = 0; done_c[u] = 0;
      first_v[u] = -1; first_b[u] = 0;
      last_b[u] = 0; occ_max[u] = 0;
      hv[u] = 1'b0; hd[u] = '0; la[u] = '0;
      for (int j = 0; j < 4; j++) fa[u][j] = '0;
    end
  endtask

  task automatic mon(
    input int u, input logic en,
    input logic [9:0] a, input logic b,
    input logic v, input logic r,
    input logic [31:0] d, input logic l,
    input logic dn
  );
    int occ;
    int n;
    n = 8 << ecfg;
    if (en) begin
      chk("rd_addr", 32'(a), 32'(rev(rd_n[u], ecfg + 3)));
      chk("rd_bank", 32'(b), 32'(ebank));
      if (rd_n[u] < 4) fa[u][rd_n[u]] = a;
      la[u] = a;
      rd_n[u]++;
    end
    if (hv[u]) chk("hold", {v, d[30:0]}, {1'b1, hd[u][30:0]});
    hv[u] = v && !r;
    hd[u] = d;
    if (v && first_v[u] < 0) first_v[u] = cyc;
    if (v && r) begin
      chk("beat", d, mw(ebank, rev(bt_n[u], ecfg + 3)));
      chk("last", 32'(l), 32'(bt_n[u] == n - 1));
      if (bt_n[u] == 0) first_b[u] = cyc;
      last_b[u] = cyc;
      bt_n[u]++;
    end
    occ = rd_n[u] - bt_n[u];
    if (occ > occ_max[u]) occ_max[u] = occ;
    if (dn) begin
      done_n[u]++;
      done_c[u] = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b1.o_sram_rd_en, b1.o_sram_rd_addr,
        b1.o_sram_rd_bank, b1.o_valid, rdy1,
        b1.o_data, b1.o_last, done1);
    mon(1, b3.o_sram_rd_en, b3.o_sram_rd_addr,
        b3.o_sram_rd_bank, b3.o_valid, rdy3,
        b3.o_data, b3.o_last, done3);
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {26'd0, b1.o_sram_rd_en, b1.o_valid, b1.o_last,
         busy1, done1, b1.o_sram_rd_bank}, 32'd0);
    chk({tag, "_addr"}, 32'(b1.o_sram_rd_addr), 32'd0);
    chk({tag, "_data"}, b1.o_data, 32'd0);
  endtask

  task automatic wait_done(input int u, input int budget);
    int i;
    i = 0;
    while (done_n[u] == 0 && i < budget) begin
      @(posedge clk);
      #1;
      if (rnd) rdy3 = 1'($urandom_range(0, 1));
      i++;
    end
    chk("timeout", 32'(done_n[u] != 0), 32'd1);
  endtask

  task automatic start(input int c, input logic b);
    @(posedge clk);
    #1;
    cfg = 3'(c); bank = b;
    ecfg = c; ebank = b;
    clr();
    done = 1'b1;
    st = cyc + 1;
  endtask

  task automatic stop();
    @(posedge clk);
    #1;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input int u, input int n, input bit tight);
    chk("rd_cnt", 32'(rd_n[u]), 32'(n));
    chk("beat_cnt", 32'(bt_n[u]), 32'(n));
    chk("done_cnt", 32'(done_n[u]), 32'd1);
    chk("done_lat", 32'(done_c[u]), 32'(last_b[u] + 1));
    if (tight)
      chk("burst", 32'(last_b[u] - first_b[u]), 32'(n - 1));
  endtask

  initial begin
    int i;
    rst = 1'b1; done = 1'b0; cfg = '0; bank = 1'b0;
    rdy1 = 1'b1; rdy3 = 1'b1; rnd = 1'b0;
    ecfg = 0; ebank = 1'b0; st = 0;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    start(0, 1'b1);
    wait_done(0, 200);
    wait_done(1, 200);
    repeat (3) @(posedge clk);
    chk("t1_first_valid", 32'(first_v[0] - st), 32'd2);
    chk("t1_a0", 32'(fa[0][0]), 32'd0);
    chk("t1_a1", 32'(fa[0][1]), 32'd4);
    chk("t1_a2", 32'(fa[0][2]), 32'd2);
    chk("t1_a3", 32'(fa[0][3]), 32'd6);
    chk("t1_alast", 32'(la[0]), 32'd7);
    chk_seq(0, 8, 1'b1);
    chk_seq(1, 8, 1'b1);
    chk("t1_busy", 32'(busy1), 32'd0);
    stop();

    start(7, 1'b0);
    wait_done(0, 3000);
    wait_done(1, 3000);
    repeat (3) @(posedge clk);
    chk("t2_a1", 32'(fa[0][1]), 32'd512);
    chk("t2_a2", 32'(fa[0][2]), 32'd256);
    chk("t2_a3", 32'(fa[0][3]), 32'd768);
    chk("t2_alast", 32'(la[0]), 32'd1023);
    chk_seq(0, 1024, 1'b1);
    chk_seq(1, 1024, 1'b1);

    clr();
    repeat (20) @(posedge clk);
    chk("t4_held", 32'(rd_n[0] + rd_n[1] + bt_n[0] + bt_n[1]),
        32'd0);
    stop();
    start(1, 1'b0);
    wait_done(0, 300);
    wait_done(1, 300);
    repeat (3) @(posedge clk);
    chk("t4_a1", 32'(fa[0][1]), 32'd8);
    chk("t4_a2", 32'(fa[0][2]), 32'd4);
    chk("t4_a3", 32'(fa[0][3]), 32'd12);
    chk("t4_alast", 32'(la[0]), 32'd15);
    chk_seq(0, 16, 1'b1);
    chk_seq(1, 16, 1'b1);
    stop();

    start(2, 1'b1);
    rnd = 1'b1;
    wait_done(1, 2000);
    rnd = 1'b0;
    rdy3 = 1'b1;
    wait_done(0, 200);
    repeat (3) @(posedge clk);
    chk_seq(0, 32, 1'b1);
    chk_seq(1, 32, 1'b0);
    chk("t3_occ", 32'(occ_max[1] <= 4), 32'd1);
    chk("t3_alast", 32'(la[1]), 32'd31);
    stop();

    start(0, 1'b1);
    i = 0;
    while (bt_n[0] < 3 && i < 100) begin
      @(posedge clk);
      i++;
    end
    chk("t5_reach", 32'(bt_n[0] >= 3), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("t5_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    clr();
    repeat (20) @(posedge clk);
    chk("t5_norestart",
        32'(rd_n[0] + rd_n[1] + bt_n[0] + bt_n[1]), 32'd0);
    chk("t5_busy", 32'(busy1 | busy3), 32'd0);
    stop();

    start(3, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    cfg = 3'd5;
    bank = 1'b0;
    wait_done(0, 500);
    wait_done(1, 500);
    repeat (3) @(posedge clk);
    chk("t6_a1", 32'(fa[0][1]), 32'd32);
    chk("t6_alast", 32'(la[0]), 32'd63);
    chk_seq(0, 64, 1'b1);
    chk_seq(1, 64, 1'b1);
    stop();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
